// File: rtl/asin_sar_if.sv
// Streaming bundle for asin_sar: input sample channel and output angle channel.
// Ports: din/din_valid/bypass -> din_ready; dout/dout_valid -> dout_ready.
interface asin_sar_if #(
    parameter int G_DWIDTH = 16
);
    logic [G_DWIDTH-1:0] din;
    logic                din_valid;
    logic                din_ready;
    logic                bypass;
    logic [G_DWIDTH-1:0] dout;
    logic                dout_valid;
    logic                dout_ready;

    modport master (
        output din, din_valid, bypass, dout_ready,
        input  din_ready, dout, dout_valid
    );

    modport slave (
        input  din, din_valid, bypass, dout_ready,
        output din_ready, dout, dout_valid
    );
endinterface

// File: rtl/asin_sar.sv
// Normalized arcsine a = (2/pi)*asin(s) by successive approximation, one bit per 7 cycles.
// Ports: clk, reset (sync, active-high), enable (0 = held in reset), bus (slave stream).
module asin_sar #(
    parameter int G_DWIDTH   = 16,
    parameter int G_TAPWIDTH = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    asin_sar_if.slave  bus
);
    localparam int MW = G_DWIDTH - 1;
    localparam int PW = G_TAPWIDTH + 4;
    localparam int KW = $clog2(MW + 1);
    // trial^2 has 2*MW fraction bits; assumes G_TAPWIDTH <= 2*MW
    localparam int SQ_SH = 2 * MW - G_TAPWIDTH;

    localparam real SCALE = 2.0 ** G_TAPWIDTH;
    localparam int C1I = $rtoi(1.5707963 * SCALE + 0.5);
    localparam int C3I = -$rtoi(0.6459641 * SCALE + 0.5);
    localparam int C5I = $rtoi(0.0796926 * SCALE + 0.5);
    localparam int C7I = -$rtoi(0.0046818 * SCALE + 0.5);
    localparam int C9I = $rtoi(0.0001604 * SCALE + 0.5);
    localparam logic signed [PW-1:0] C1 = PW'(C1I);
    localparam logic signed [PW-1:0] C3 = PW'(C3I);
    localparam logic signed [PW-1:0] C5 = PW'(C5I);
    localparam logic signed [PW-1:0] C7 = PW'(C7I);
    localparam logic signed [PW-1:0] C9 = PW'(C9I);

    typedef enum logic [3:0] {
        SM_INIT, SM_GET_INPUT, SM_SETUP, SM_SQUARE, SM_HORNER,
        SM_FINAL, SM_COMPARE, SM_DONE, SM_SEND_OUTPUT
    } state_t;

    state_t                state_q, state_d;
    logic                  din_ready_q, din_ready_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [G_DWIDTH-1:0]   dout_q, dout_d;
    logic                  sign_q, sign_d;
    logic [MW-1:0]         mag_q, mag_d;
    logic [MW-1:0]         acc_q, acc_d;
    logic [KW-1:0]         k_q, k_d;
    logic [1:0]            h_q, h_d;
    logic signed [PW-1:0]  x2_q, x2_d;
    logic signed [PW-1:0]  p_q, p_d;
    logic signed [PW-1:0]  y_q, y_d;

    logic [MW-1:0]         trial;
    logic signed [PW-1:0]  trial_s, t_s, coef, mul_a, mul_b, mul_r;
    logic signed [2*PW-1:0] mul_p;
    logic [G_DWIDTH-1:0]   abs_w, acc_ext;
    logic [MW-1:0]         mag_w;

    assign trial   = acc_q | (MW'(1) << k_q);
    assign trial_s = {{(PW-MW){1'b0}}, trial};
    // |s| aligned to the datapath fraction width
    assign t_s = {{(PW-G_TAPWIDTH){1'b0}}, mag_q, {(G_TAPWIDTH-MW){1'b0}}};
    assign acc_ext = {1'b0, acc_q};

    // -2^(N-1) has no positive twin, so it clips to full scale
    assign abs_w = bus.din[G_DWIDTH-1] ? -bus.din : bus.din;
    assign mag_w = (bus.din == {1'b1, {MW{1'b0}}}) ? {MW{1'b1}}
                                                  : abs_w[MW-1:0];

    always_comb begin
        coef = C1;
        unique case (h_q)
            2'd0: coef = C7;
            2'd1: coef = C5;
            2'd2: coef = C3;
            2'd3: coef = C1;
        endcase
    end

    // Single multiplier shared by square, Horner and final product
    always_comb begin
        mul_a = p_q;
        mul_b = x2_q;
        unique case (state_q)
            SM_SQUARE: begin
                mul_a = trial_s;
                mul_b = trial_s;
            end
            SM_FINAL: mul_b = trial_s;
            default: ;
        endcase
    end

    assign mul_p = mul_a * mul_b;

    always_comb begin
        mul_r = PW'(mul_p >>> G_TAPWIDTH);
        unique case (state_q)
            SM_SQUARE: mul_r = PW'(mul_p >>> SQ_SH);
            SM_FINAL:  mul_r = PW'(mul_p >>> MW);
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        din_ready_d  = din_ready_q;
        dout_valid_d = dout_valid_q;
        dout_d       = dout_q;
        sign_d       = sign_q;
        mag_d        = mag_q;
        acc_d        = acc_q;
        k_d          = k_q;
        h_d          = h_q;
        x2_d         = x2_q;
        p_d          = p_q;
        y_d          = y_q;
        unique case (state_q)
            SM_INIT: begin
                din_ready_d = 1'b1;
                state_d     = SM_GET_INPUT;
            end
            SM_GET_INPUT: begin
                if (bus.din_valid && din_ready_q) begin
                    din_ready_d = 1'b0;
                    sign_d      = bus.din[G_DWIDTH-1];
                    mag_d       = mag_w;
                    if (bus.bypass) begin
                        dout_d       = bus.din;
                        dout_valid_d = 1'b1;
                        state_d      = SM_SEND_OUTPUT;
                    end else begin
                        state_d = SM_SETUP;
                    end
                end
            end
            SM_SETUP: begin
                acc_d   = '0;
                k_d     = KW'(MW - 1);
                state_d = SM_SQUARE;
            end
            SM_SQUARE: begin
                x2_d    = mul_r;
                p_d     = C9;
                h_d     = 2'd0;
                state_d = SM_HORNER;
            end
            SM_HORNER: begin
                p_d = mul_r + coef;
                h_d = h_q + 2'd1;
                if (h_q == 2'd3) state_d = SM_FINAL;
            end
            SM_FINAL: begin
                y_d     = mul_r;
                state_d = SM_COMPARE;
            end
            SM_COMPARE: begin
                if (y_q <= t_s) acc_d = trial;
                if (k_q == '0) begin
                    state_d = SM_DONE;
                end else begin
                    k_d     = k_q - KW'(1);
                    state_d = SM_SQUARE;
                end
            end
            SM_DONE: begin
                dout_d       = sign_q ? -acc_ext : acc_ext;
                dout_valid_d = 1'b1;
                state_d      = SM_SEND_OUTPUT;
            end
            SM_SEND_OUTPUT: begin
                if (dout_valid_q && bus.dout_ready) begin
                    dout_valid_d = 1'b0;
                    din_ready_d  = 1'b1;
                    state_d      = SM_GET_INPUT;
                end
            end
            default: state_d = SM_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state_q      <= SM_INIT;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            sign_q       <= 1'b0;
            mag_q        <= '0;
            acc_q        <= '0;
            k_q          <= '0;
            h_q          <= '0;
            x2_q         <= '0;
            p_q          <= '0;
            y_q          <= '0;
        end else begin
            state_q      <= state_d;
            din_ready_q  <= din_ready_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            sign_q       <= sign_d;
            mag_q        <= mag_d;
            acc_q        <= acc_d;
            k_q          <= k_d;
            h_q          <= h_d;
            x2_q         <= x2_d;
            p_q          <= p_d;
            y_q          <= y_d;
        end
    end

    assign bus.din_ready  = din_ready_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
endmodule
